// File: rtl/stack_behaviour_lite.sv
// -----------------------------------------------------------------------------
// stack_behaviour_lite
//
// Five-entry, 4-bit LIFO stack driven by a 2-bit command port. Storage is a
// circular buffer with no full/empty detection: pushing past five entries
// overwrites the oldest one, and popping an empty stack wraps the pointer and
// returns whatever the addressed slot holds.
//
// Ports:
//   CLK      in   1  system clock, all state changes on the rising edge
//   RESET    in   1  synchronous active-high reset, overrides COMMAND
//   COMMAND  in   2  00 NOP, 01 PUSH, 10 POP, 11 GET
//   INDEX    in   3  depth for GET (0 = top), taken modulo 5
//   I_DATA   in   4  data written on PUSH, ignored otherwise
//   O_DATA   out  4  registered result of the last POP or GET
// -----------------------------------------------------------------------------
module stack_behaviour_lite (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] COMMAND,
   input  logic [2:0] INDEX,
   input  logic [3:0] I_DATA,
   output logic [3:0] O_DATA
);

   localparam int unsigned DEPTH = 5;

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;
   localparam logic [1:0] CMD_GET  = 2'b11;

   logic [3:0] mem_q [DEPTH];
   logic [3:0] mem_d [DEPTH];
   logic [2:0] sp_q;
   logic [2:0] sp_d;
   logic [3:0] o_data_q;
   logic [3:0] o_data_d;

   logic [2:0] top_slot;
   logic [2:0] get_slot;
   logic [2:0] next_slot;

   // Reduces a small non-negative value (at most 14) modulo 5. Callers bias
   // their operands upward by a multiple of 5 so that what would be a negative
   // intermediate never appears, and the result lands in 0..4.
   function automatic logic [2:0] wrap5(input logic [4:0] value);
      if (value >= 5'd10) begin
         return 3'(value - 5'd10);
      end else if (value >= 5'd5) begin
         return 3'(value - 5'd5);
      end else begin
         return value[2:0];
      end
   endfunction

   // Slot addresses derived from the stack pointer. (sp-1) mod 5 is formed as
   // sp+4, and (sp-1-INDEX) mod 5 as sp+9-INDEX, which stays within 2..13 for
   // every sp in 0..4 and INDEX in 0..7.
   always_comb begin
      top_slot  = wrap5({2'b00, sp_q} + 5'd4);
      get_slot  = wrap5({2'b00, sp_q} + 5'd9 - {2'b00, INDEX});
      next_slot = wrap5({2'b00, sp_q} + 5'd1);
   end

   // Next-state logic. Everything holds by default; only the one command
   // decoded this cycle modifies storage, the pointer or the read register.
   always_comb begin
      mem_d    = mem_q;
      sp_d     = sp_q;
      o_data_d = o_data_q;
      case (COMMAND)
         CMD_NOP: begin
         end
         CMD_PUSH: begin
            mem_d[sp_q] = I_DATA;
            sp_d        = next_slot;
         end
         CMD_POP: begin
            // Popped data is left in storage; later GETs can still see it.
            o_data_d = mem_q[top_slot];
            sp_d     = top_slot;
         end
         CMD_GET: begin
            o_data_d = mem_q[get_slot];
         end
         default: begin
         end
      endcase
   end

   // State registers with synchronous reset, which clears the whole buffer
   // so that underflow after reset reads back zeros.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 4'd0;
         end
         sp_q     <= 3'd0;
         o_data_q <= 4'd0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         sp_q     <= sp_d;
         o_data_q <= o_data_d;
      end
   end

   assign O_DATA = o_data_q;

endmodule

// File: tb/tb_stack_behaviour_lite.sv
// -----------------------------------------------------------------------------
// tb_stack_behaviour_lite
//
// Directed bench for stack_behaviour_lite. Each applied cycle pushes the
// hand-computed O_DATA value expected after that edge into a scoreboard queue;
// an independent monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_stack_behaviour_lite;

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;
   localparam logic [1:0] CMD_GET  = 2'b11;

   logic       CLK;
   logic       RESET;
   logic [1:0] COMMAND;
   logic [2:0] INDEX;
   logic [3:0] I_DATA;
   logic [3:0] O_DATA;

   typedef struct {
      logic [3:0] expected;
      string      name;
   } scbEntry_t;

   scbEntry_t scoreboard[$];

   int checkCount;
   int failCount;

   stack_behaviour_lite dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .COMMAND(COMMAND),
      .INDEX  (INDEX),
      .I_DATA (I_DATA),
      .O_DATA (O_DATA)
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Compares one observed value against its expectation and counts it.
   task automatic checkOutput(input string name, input logic [3:0] actual,
                              input logic [3:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: O_DATA=%0d expected %0d", name, actual, expected);
      end
   endtask

   // Drives one command away from the rising edge, lets the DUT sample it, and
   // then records what O_DATA must read after that edge.
   task automatic applyStimulus(input logic rst, input logic [1:0] cmd,
                                input logic [2:0] idx, input logic [3:0] data,
                                input logic [3:0] expected, input string name);
      scbEntry_t entry;
      @(negedge CLK);
      RESET   = rst;
      COMMAND = cmd;
      INDEX   = idx;
      I_DATA  = data;
      @(posedge CLK);
      entry.expected = expected;
      entry.name     = name;
      scoreboard.push_back(entry);
   endtask

   // Monitor: on each falling edge, any expectation recorded at the preceding
   // rising edge is checked against the live output.
   initial begin
      scbEntry_t entry;
      forever begin
         @(negedge CLK);
         if (scoreboard.size() > 0) begin
            entry = scoreboard.pop_front();
            checkOutput(entry.name, O_DATA, entry.expected);
         end
      end
   end

   // Directed sequence with hand-computed results.
   initial begin
      logic [3:0] getExp  [8];
      logic [3:0] popExp  [5];
      logic [3:0] pairExp [5];
      int         drain;

      getExp  = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd5, 4'd4, 4'd3};
      popExp  = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
      pairExp = '{4'd4, 4'd2, 4'd5, 4'd3, 4'd1};

      checkCount = 0;
      failCount  = 0;
      RESET      = 1'b0;
      COMMAND    = CMD_NOP;
      INDEX      = 3'd0;
      I_DATA     = 4'd0;

      // Reset, fill exactly five entries; O_DATA must stay 0.
      applyStimulus(1'b1, CMD_NOP, 3'd0, 4'd0, 4'd0, "reset");
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, CMD_PUSH, 3'd0, 4'(i), 4'd0, $sformatf("push%0d_hold", i));
      end
      applyStimulus(1'b0, CMD_NOP, 3'd0, 4'hA, 4'd0, "nop_hold");

      // GET at every index, including the ones that wrap past depth 5.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, CMD_GET, 3'(i), 4'hF, getExp[i], $sformatf("get%0d", i));
      end

      // POP / GET pairs, the GETs landing on already-popped slots.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, CMD_POP, 3'd7, 4'hC, popExp[i], $sformatf("pop%0d", i));
         applyStimulus(1'b0, CMD_GET, 3'(i), 4'h3, pairExp[i], $sformatf("pair_get%0d", i));
      end
      applyStimulus(1'b0, CMD_NOP, 3'd2, 4'h6, 4'd1, "nop_hold_after_get");

      // Reset in mid-sequence, then underflow POPs read cleared storage.
      applyStimulus(1'b0, CMD_PUSH, 3'd0, 4'd7, 4'd1, "push7_hold");
      applyStimulus(1'b0, CMD_PUSH, 3'd0, 4'd8, 4'd1, "push8_hold");
      applyStimulus(1'b1, CMD_POP, 3'd0, 4'd0, 4'd0, "midreset");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, CMD_POP, 3'd0, 4'hE, 4'd0, $sformatf("underflow_pop%0d", i));
      end

      // Overflow: the sixth PUSH overwrites the oldest entry.
      applyStimulus(1'b1, CMD_NOP, 3'd0, 4'd0, 4'd0, "reset_overflow");
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b0, CMD_PUSH, 3'd0, 4'(i), 4'd0, $sformatf("ovf_push%0d_hold", i));
      end
      applyStimulus(1'b0, CMD_GET, 3'd0, 4'd0, 4'd6, "ovf_get0");
      applyStimulus(1'b0, CMD_GET, 3'd4, 4'd0, 4'd2, "ovf_get4");
      applyStimulus(1'b0, CMD_GET, 3'd5, 4'd0, 4'd6, "ovf_get5");
      applyStimulus(1'b0, CMD_POP, 3'd0, 4'd0, 4'd6, "ovf_pop");

      // RESET beats a simultaneous PUSH: nothing is stored, sp stays 0.
      applyStimulus(1'b1, CMD_PUSH, 3'd0, 4'd9, 4'd0, "reset_with_push");
      applyStimulus(1'b0, CMD_GET, 3'd0, 4'd0, 4'd0, "get0_after_reset_push");
      applyStimulus(1'b0, CMD_PUSH, 3'd0, 4'd11, 4'd0, "push11_hold");
      applyStimulus(1'b0, CMD_GET, 3'd0, 4'd0, 4'd11, "get0_after_push11");
      applyStimulus(1'b0, CMD_GET, 3'd1, 4'd0, 4'd0, "get1_after_push11");

      // Let the monitor drain, bounded so the bench always ends.
      drain = 0;
      while (scoreboard.size() > 0 && drain < 10) begin
         @(posedge CLK);
         drain++;
      end
      if (scoreboard.size() > 0) begin
         failCount++;
         $display("[TB] FAIL drain: pending=%0d expected 0", scoreboard.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/stack_behaviour_lite.md
# stack_behaviour_lite

Five-entry, 4-bit LIFO stack that runs on one clock and is driven by a 2-bit command port. It supports push, pop and random read-by-depth (GET). Storage is a circular buffer with no full or empty detection, so overflow overwrites the oldest entry and underflow wraps. It is a small standalone storage block for command-driven datapaths and is exercised directly by its bench.

## Interface
- No parameters. Depth 5, data width 4 and index width 3 are fixed.
- CLK  input  1  system clock. All state changes on the rising edge.
- RESET  input  1  reset, synchronous and active-high. Sampled on the CLK rising edge and takes priority over COMMAND.
- COMMAND  input  2  operation select: 2'b00 NOP, 2'b01 PUSH, 2'b10 POP, 2'b11 GET.
- INDEX  input  3  depth for GET. 0 = top of stack. Range 0..7, reduced modulo 5.
- I_DATA  input  4  data to store on PUSH. Ignored for every other command, and may be X then.
- O_DATA  output  4  registered read data from POP or GET.

## Operation
- State:
  - mem[0..4], 4 bits each.
  - Pointer sp in 0..4, the next free slot. Top of stack = mem[(sp-1) mod 5].
- RESET=1 at a rising edge:
  - all mem entries <= 0, sp <= 0, O_DATA <= 0.
  - COMMAND is ignored in that cycle.
- NOP: no state change. O_DATA holds its value.
- PUSH:
  - mem[sp] <= I_DATA, sp <= (sp+1) mod 5.
  - O_DATA holds its value.
- POP:
  - O_DATA <= mem[(sp-1) mod 5], sp <= (sp-1) mod 5.
  - mem is unchanged; the popped value stays in storage.
- GET:
  - O_DATA <= mem[(sp-1-INDEX) mod 5], with INDEX taken as an unsigned value 0..7.
  - sp and mem are unchanged.
- Modular arithmetic: compute in a signed or widened form so that negative intermediates wrap correctly. Example: sp=0, INDEX=4 gives slot (0-1-4) mod 5 = 0.
- Overflow: a sixth and later PUSH silently overwrites the oldest entry. There is no flag.
- Underflow: POP or GET on an empty stack returns whatever the addressed slot holds and wraps sp. Right after reset this is 0. There is no flag.
- Only one command is possible per cycle. The encoding is exclusive, so simultaneous push and pop cannot occur.

## Timing
- Commands and data are sampled on the CLK rising edge. The bench changes inputs away from rising edges.
- Latency:
  - O_DATA shows the POP/GET result immediately after the rising edge that sampled the command, and holds it until the next POP/GET or RESET.
  - PUSHed data is readable by a GET or POP in the very next cycle.
- Reset:
  - Takes effect at the first rising edge with RESET=1. O_DATA is 0 after that edge.
  - A reset in the middle of a command sequence discards all contents.
  - Before the first reset, O_DATA and the storage are undefined.
- O_DATA never changes on the falling edge and never changes combinationally with INDEX or COMMAND.

## Test plan
- Reset, then PUSH 1,2,3,4,5 in consecutive cycles, then NOP -> O_DATA stays 0 throughout.
- Continue with GET INDEX 0..7 -> O_DATA = 5,4,3,2,1,5,4,3 (modulo-5 wrap).
- Continue with the pairs POP, GET i for i=0..4:
  - POP results: 5, 4, 3, 2, 1.
  - GET results: 4, 2, 5, 3, 1. These use the wrapped slots of the still-stored old data.
- Apply RESET mid-sequence, then POP 5 times -> O_DATA = 0 every cycle (underflow returns cleared storage).
- Reset, PUSH 1..6 -> GET 0 = 6, GET 4 = 2, GET 5 = 6; the oldest entry is overwritten.
- Present COMMAND=PUSH together with RESET=1 -> sp stays 0 and a following GET 0 returns 0.
